// File: rtl/arb_pkg.sv
// arb_pkg: shared types, sizes and helpers for the round-robin mux arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    rr_pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[ptr + SEL_W'(k)]) rr_pick = ptr + SEL_W'(k);
  endfunction
endpackage

// File: rtl/rr_priority_enc.sv
// rr_priority_enc: rotate requests by ptr, pick the lowest set bit, rotate the index back.
module rr_priority_enc
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;
  always_comb begin
    w_rot = '0;
    w_off = '0;
    for (int k = 0; k < N_REQ; k++) w_rot[k] = req[ptr + SEL_W'(k)];
    for (int k = N_REQ - 1; k >= 0; k--)
      if (w_rot[k]) w_off = SEL_W'(k);
  end
  assign idx = w_off + ptr;
  assign any = |req;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of the shared 8:1 mux channel; drives select,
// one-hot grant and the valid/ready handshake, with capped locked bursts.
module mux_rr_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CW       = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic [N_REQ-1:0] beat_done
);
  state_t           r_state, w_state;
  logic [SEL_W-1:0] r_ptr, w_ptr, w_sel, w_scan, w_win;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [N_REQ-1:0] w_gnt, w_done;
  logic             w_valid, w_any, w_hs, w_hold;
  // On release the scan starts just past the served requester, making it lowest priority
  assign w_scan = (r_state == GRANT) ? sel + 1'b1 : r_ptr;
  assign w_hs   = out_valid & out_ready;
  assign w_hold = lock[sel] & req[sel] & (int'(r_cnt) + 1 < HOLD_MAX);
  rr_priority_enc u_enc (.req(req), .ptr(w_scan), .idx(w_win), .any(w_any));
  always_comb begin
    w_state = r_state;
    w_sel   = sel;
    w_gnt   = gnt;
    w_valid = out_valid;
    w_done  = '0;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    if (r_state == IDLE) begin
      if (w_any) begin
        w_state = GRANT;
        w_sel   = w_win;
        w_gnt   = onehot(w_win);
        w_valid = 1'b1;
        w_cnt   = '0;
      end
    end else if (w_hs) begin
      w_done = onehot(sel);
      if (w_hold) w_cnt = r_cnt + 1'b1;
      else begin
        w_ptr   = sel + 1'b1;
        w_cnt   = '0;
        w_state = w_any ? GRANT : IDLE;
        w_sel   = w_any ? w_win : sel;
        w_gnt   = w_any ? onehot(w_win) : '0;
        w_valid = w_any;
      end
    end else if (!req[sel]) begin
      w_state = IDLE;
      w_gnt   = '0;
      w_valid = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      beat_done <= '0;
    end else begin
      r_state   <= w_state;
      r_ptr     <= w_ptr;
      r_cnt     <= w_cnt;
      sel       <= w_sel;
      gnt       <= w_gnt;
      out_valid <= w_valid;
      beat_done <= w_done;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios plus random traffic checked against a
// behavioural ownership model of the round-robin arbiter.
module tb_mux_rr_arbiter;
  localparam int HOLD_MAX = 4;
  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] req, lock;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt, beat_done;
  logic       out_valid;
  int         n_chk = 0, n_pass = 0;
  bit         m_busy;
  int         m_owner, m_ptr, m_beats;
  logic [7:0] exp_done;
  mux_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CW(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .lock(lock), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .out_valid(out_valid), .beat_done(beat_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic int pick(int p, logic [7:0] r);
    for (int i = 0; i < 8; i++) if (r[(p + i) % 8]) return (p + i) % 8;
    return -1;
  endfunction
  // Model: who owns the channel, how many beats it has completed, where the scan starts
  task automatic model_edge();
    exp_done = '0;
    if (!m_busy) begin
      if (req != 0) begin
        m_owner = pick(m_ptr, req);
        m_busy  = 1;
        m_beats = 0;
      end
    end else if (out_ready) begin
      exp_done[m_owner] = 1'b1;
      m_beats++;
      if (!(lock[m_owner] && req[m_owner] && m_beats < HOLD_MAX)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_beats = 0;
        if (req != 0) m_owner = pick(m_ptr, req);
        else m_busy = 0;
      end
    end else if (!req[m_owner]) m_busy = 0;
  endtask
  task automatic compare();
    chk("valid", 32'(out_valid), 32'(m_busy));
    chk("gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
    if (m_busy) chk("sel", 32'(sel), 32'(m_owner));
    chk("done", 32'(beat_done), 32'(exp_done));
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1 compare();
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; exp_done = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_done", 32'(beat_done), 0);
    #1 rstn = 1'b1;
  endtask
  initial begin
    int n1;
    int fair[4] = '{0, 7, 0, 7};
    req = 8'hFF; lock = '0; out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rr_order", 32'(sel), 32'(i % 8));
    end
    do_reset();
    req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fair_order", 32'(sel), 32'(fair[i]));
    end
    do_reset();
    req = 8'h06; lock = 8'h02; n1 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n1 += int'(beat_done[1]);
    end
    chk("lock_beats", 32'(n1), 4);
    chk("after_lock_sel", 32'(sel), 2);
    do_reset();
    req = 8'h08; lock = '0; out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_sel", 32'(sel), 3);
      chk("bp_done", 32'(beat_done), 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_done", 32'(beat_done), 32'h08);
    do_reset();
    req = 8'h20; out_ready = 1'b0;
    step();
    req = 8'h00;
    step();
    chk("wd_valid", 32'(out_valid), 0);
    req = 8'h20;
    step();
    chk("wd_regrant", 32'(sel), 5);
    do_reset();
    req = 8'h20; out_ready = 1'b1;
    step();
    req = 8'h40; lock = 8'h40;
    step();
    step();
    do_reset();
    req = 8'h41; lock = '0;
    step();
    chk("post_reset_sel", 32'(sel), 0);
    for (int i = 0; i < 400; i++) begin
      req       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
      lock      = 8'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
